// File: rtl/ilv_pkg.sv
// Shared constants and geometry helpers for the convolutional interleaver.
// Branch b holds b*M bytes; all branches share one flat memory, packed
// back to back starting with branch 1 at offset 0.
package ilv_pkg;

   localparam int ILV_DATA_W   = 8;
   localparam int ILV_BRANCHES = 12;
   localparam int ILV_M        = 17;

   // Width needed to index n items, never less than one bit.
   function automatic int ilv_clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Number of cells in branch b.
   function automatic int ilv_depth(input int b, input int m);
      return b * m;
   endfunction

   // First cell of branch b in the flat memory.
   function automatic int ilv_base(input int b, input int m);
      return (m * b * (b - 1)) / 2;
   endfunction

   // Total cells over all delay branches.
   function automatic int ilv_total(input int branches, input int m);
      return (m * branches * (branches - 1)) / 2;
   endfunction

   localparam int ILV_TOTAL  = ilv_total(ILV_BRANCHES, ILV_M);
   localparam int ILV_PTR_W  = ilv_clog2_min1(ILV_BRANCHES);
   localparam int ILV_WP_W   = ilv_clog2_min1((ILV_BRANCHES - 1) * ILV_M);
   localparam int ILV_ADDR_W = ilv_clog2_min1(ILV_TOTAL);

endpackage

// File: rtl/ilv_delay_ram.sv
// Flat single-port delay memory. A write returns the previous contents of
// the same cell on the next clock. No reset: stale contents are masked by
// the core until each branch has been filled once.
module ilv_delay_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Read-before-write on the same cell.
   always_ff @(posedge clk) begin
      if (en) begin
         rdata     <= mem[addr];
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/conv_interleaver_core.sv
// Convolutional (Forney) interleaver core. Accepted bytes are distributed
// round-robin over BRANCHES branches; branch b delays by b*M visits.
// A single output register with valid/ready feeds the downstream stage.
// Optional macro SYNC_ALIGN_EN: a byte flagged with in_sync while the
// commutator is not at branch 0 is forced onto branch 0 and sync_err pulses.
module conv_interleaver_core
   import ilv_pkg::*;
#(
   parameter int DATA_W   = ILV_DATA_W,
   parameter int BRANCHES = ILV_BRANCHES,
   parameter int M        = ILV_M
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [DATA_W-1:0]                     data_in,
   input  logic                                  in_sync,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [DATA_W-1:0]                     data_out,
   output logic [ilv_clog2_min1(BRANCHES)-1:0]   out_branch,
   output logic                                  out_primed,
   output logic                                  sync_err
);

   localparam int PTR_W  = ilv_clog2_min1(BRANCHES);
   localparam int WP_W   = ilv_clog2_min1((BRANCHES - 1) * M);
   localparam int TOTAL  = ilv_total(BRANCHES, M);
   localparam int ADDR_W = ilv_clog2_min1(TOTAL);

   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  ptr_nxt;
   logic [PTR_W-1:0]  sel_branch;
   logic              sync_hit;
   logic              accept;
   logic [WP_W-1:0]   wp [BRANCHES];
   logic [BRANCHES-1:0] primed;

   logic [ADDR_W-1:0] base_tab [BRANCHES];
   logic [WP_W-1:0]   last_tab [BRANCHES];

   logic              ram_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rdata;

   logic [DATA_W-1:0] bypass_q;
   logic              from_ram_q;

   // Per-branch base offset and last write-pointer value, fixed at elaboration.
   for (genvar g = 0; g < BRANCHES; g++) begin : g_tab
      localparam int LAST = (g == 0) ? 0 : ilv_depth(g, M) - 1;
      assign base_tab[g] = ADDR_W'(ilv_base(g, M));
      assign last_tab[g] = WP_W'(LAST);
   end

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Branch selection for the current byte, including optional sync realignment.
   always_comb begin
      sel_branch = ptr;
      sync_hit   = 1'b0;
`ifdef SYNC_ALIGN_EN
      if (in_sync && (ptr != '0)) begin
         sel_branch = '0;
         sync_hit   = 1'b1;
      end
`endif
      if (sync_hit) begin
         ptr_nxt = PTR_W'(1);
      end else if (ptr == PTR_W'(BRANCHES - 1)) begin
         ptr_nxt = '0;
      end else begin
         ptr_nxt = ptr + 1'b1;
      end
   end

`ifndef SYNC_ALIGN_EN
   logic unused_sync;
   assign unused_sync = in_sync;
`endif

   // Branch 0 never touches memory; every other branch reads and rewrites one cell.
   always_comb begin
      ram_en   = accept && (sel_branch != '0);
      ram_addr = base_tab[sel_branch] + ADDR_W'(wp[sel_branch]);
   end

   ilv_delay_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (TOTAL),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .addr  (ram_addr),
      .wdata (data_in),
      .rdata (ram_rdata)
   );

   // Commutator pointer, per-branch write pointers and primed flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr    <= '0;
         primed <= '0;
         for (int b = 0; b < BRANCHES; b++) begin
            wp[b] <= '0;
         end
      end else if (accept) begin
         ptr <= ptr_nxt;
         if (sel_branch != '0) begin
            if (wp[sel_branch] == last_tab[sel_branch]) begin
               wp[sel_branch]     <= '0;
               primed[sel_branch] <= 1'b1;
            end else begin
               wp[sel_branch] <= wp[sel_branch] + 1'b1;
            end
         end
      end
   end

   // Output stage; the RAM read port is only enabled on accept, so its data
   // stays put during a stall just like the other output fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_branch <= '0;
         out_primed <= 1'b0;
         bypass_q   <= '0;
         from_ram_q <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_branch <= sel_branch;
         out_primed <= (sel_branch == '0) ? 1'b1 : primed[sel_branch];
         from_ram_q <= (sel_branch != '0);
         if (sel_branch == '0) begin
            bypass_q <= data_in;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign data_out = from_ram_q ? (out_primed ? ram_rdata : '0) : bypass_q;

`ifdef SYNC_ALIGN_EN
   logic sync_q;

   // One-cycle misalignment pulse following the realigned accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 1'b0;
      end else begin
         sync_q <= accept && sync_hit;
      end
   end

   assign sync_err = sync_q;
`else
   assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_interleaver_core.sv
// Bench for conv_interleaver_core: a small instance (3 branches, M=2) for
// the hand-checked sequences and a default-parameter instance for a long
// randomized stream, both checked against a per-branch FIFO model.
module tb_conv_interleaver_core;

   logic clk;
   logic reset;

   logic       s_in_valid, s_in_ready, s_in_sync, s_out_valid, s_out_ready;
   logic       s_out_primed, s_sync_err;
   logic [7:0] s_data_in, s_data_out;
   logic [1:0] s_out_branch;

   logic       d_in_valid, d_in_ready, d_in_sync, d_out_valid, d_out_ready;
   logic       d_out_primed, d_sync_err;
   logic [7:0] d_data_in, d_data_out;
   logic [3:0] d_out_branch;

   conv_interleaver_core #(.DATA_W(8), .BRANCHES(3), .M(2)) dut_s (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (s_in_valid),
      .in_ready   (s_in_ready),
      .data_in    (s_data_in),
      .in_sync    (s_in_sync),
      .out_valid  (s_out_valid),
      .out_ready  (s_out_ready),
      .data_out   (s_data_out),
      .out_branch (s_out_branch),
      .out_primed (s_out_primed),
      .sync_err   (s_sync_err)
   );

   conv_interleaver_core dut_d (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (d_in_valid),
      .in_ready   (d_in_ready),
      .data_in    (d_data_in),
      .in_sync    (d_in_sync),
      .out_valid  (d_out_valid),
      .out_ready  (d_out_ready),
      .data_out   (d_data_out),
      .out_branch (d_out_branch),
      .out_primed (d_out_primed),
      .sync_err   (d_sync_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0] d;
      logic [3:0] br;
      logic       pr;
   } exp_t;

   localparam int NBR  [2] = '{3, 12};
   localparam int MDEL [2] = '{2, 17};

   logic [7:0] mq [2][12][$];
   exp_t       expq [2][$];
   int         mptr [2];
   logic       mvalid [2];
   logic       pend_se [2];

   logic [7:0] s_log_d [$];
   int         s_log_br [$];
   logic       s_log_pr [$];
   int         vis11;

   task automatic model_reset(input int i);
      for (int b = 0; b < 12; b++) mq[i][b].delete();
      expq[i].delete();
      mptr[i]    = 0;
      mvalid[i]  = 1'b0;
      pend_se[i] = 1'b0;
      if (i == 0) begin
         s_log_d.delete();
         s_log_br.delete();
         s_log_pr.delete();
      end else begin
         vis11 = 0;
      end
   endtask

   task automatic sb_step(input int i, input logic iv, input logic ir, input logic [7:0] din,
                          input logic sy, input logic ov, input logic ordy,
                          input logic [7:0] dout, input int obr, input logic opr, input logic se);
      exp_t e;
      int   b;
      logic hit;
      logic acc;
      check($sformatf("out_valid_%0d", i), ov, mvalid[i]);
      check($sformatf("in_ready_%0d", i), ir, !mvalid[i] || ordy);
      check($sformatf("sync_err_%0d", i), se, pend_se[i]);
      if (mvalid[i] && ordy) begin
         if (expq[i].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL model_underflow_%0d: output with no expected byte", i);
         end else begin
            e = expq[i].pop_front();
            check($sformatf("data_%0d", i), dout, e.d);
            check($sformatf("branch_%0d", i), obr, e.br);
            check($sformatf("primed_%0d", i), opr, e.pr);
            if (i == 0) begin
               s_log_d.push_back(dout);
               s_log_br.push_back(obr);
               s_log_pr.push_back(opr);
            end else if (e.br == 4'd11) begin
               vis11++;
               if (vis11 == 187) check("primed11_visit187", opr, 1'b0);
               if (vis11 == 188) check("primed11_visit188", opr, 1'b1);
            end
         end
      end
      acc = iv && (!mvalid[i] || ordy);
      hit = 1'b0;
      if (acc) begin
         b = mptr[i];
`ifdef SYNC_ALIGN_EN
         if (sy && mptr[i] != 0) begin
            b       = 0;
            hit     = 1'b1;
            mptr[i] = 1;
         end else begin
            mptr[i] = (mptr[i] + 1) % NBR[i];
         end
`else
         mptr[i] = (mptr[i] + 1) % NBR[i];
`endif
         e.br = 4'(b);
         if (b == 0) begin
            e.d  = din;
            e.pr = 1'b1;
         end else begin
            mq[i][b].push_back(din);
            if (mq[i][b].size() > b * MDEL[i]) begin
               e.d  = mq[i][b].pop_front();
               e.pr = 1'b1;
            end else begin
               e.d  = 8'h00;
               e.pr = 1'b0;
            end
         end
         expq[i].push_back(e);
         mvalid[i] = 1'b1;
      end else if (ordy) begin
         mvalid[i] = 1'b0;
      end
      pend_se[i] = hit;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         model_reset(0);
         model_reset(1);
      end else begin
         sb_step(0, s_in_valid, s_in_ready, s_data_in, s_in_sync, s_out_valid, s_out_ready,
                 s_data_out, int'(s_out_branch), s_out_primed, s_sync_err);
         sb_step(1, d_in_valid, d_in_ready, d_data_in, d_in_sync, d_out_valid, d_out_ready,
                 d_data_out, int'(d_out_branch), d_out_primed, d_sync_err);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic s_send(input logic [7:0] d, input logic sy);
      int w = 0;
      s_in_valid = 1'b1;
      s_data_in  = d;
      s_in_sync  = sy;
      @(negedge clk);
      while (!s_in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!s_in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL s_accept_timeout: in_ready 0 expected 1");
      end
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      s_in_sync  = 1'b0;
   endtask

   task automatic s_idle(input int n);
      s_in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic d_send(input logic [7:0] d);
      int w = 0;
      bit done = 0;
      d_in_valid = 1'b1;
      d_data_in  = d;
      while (!done && w < 100) begin
         d_out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         done = d_in_ready;
         @(posedge clk); #1;
         w++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL d_accept_timeout: in_ready 0 expected 1");
      end
      d_in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   typedef struct {
      int         k;
      logic [7:0] d;
      logic       pr;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   task automatic check_table(input string tag);
      int k;
      check({tag, "_count"}, s_log_d.size(), 18);
      for (int i = 0; i < NV; i++) begin
         k = tbl[i].k;
         if (k < s_log_d.size()) begin
            check($sformatf("%s_k%0d_data", tag, k), s_log_d[k], tbl[i].d);
            check($sformatf("%s_k%0d_primed", tag, k), s_log_pr[k], tbl[i].pr);
            check($sformatf("%s_k%0d_branch", tag, k), s_log_br[k], k % 3);
         end
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      tbl[0]  = '{0,  8'h01, 1'b1};
      tbl[1]  = '{1,  8'h00, 1'b0};
      tbl[2]  = '{2,  8'h00, 1'b0};
      tbl[3]  = '{3,  8'h04, 1'b1};
      tbl[4]  = '{4,  8'h00, 1'b0};
      tbl[5]  = '{5,  8'h00, 1'b0};
      tbl[6]  = '{6,  8'h07, 1'b1};
      tbl[7]  = '{7,  8'h02, 1'b1};
      tbl[8]  = '{10, 8'h05, 1'b1};
      tbl[9]  = '{11, 8'h00, 1'b0};
      tbl[10] = '{13, 8'h08, 1'b1};
      tbl[11] = '{14, 8'h03, 1'b1};
      tbl[12] = '{16, 8'h0B, 1'b1};
      tbl[13] = '{17, 8'h06, 1'b1};

      reset       = 1'b1;
      s_in_valid  = 1'b0; s_in_sync = 1'b0; s_data_in = 8'h00; s_out_ready = 1'b1;
      d_in_valid  = 1'b0; d_in_sync = 1'b0; d_data_in = 8'h00; d_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_in_ready", s_in_ready, 1'b1);
      check("rst_s_out_valid", s_out_valid, 1'b0);
      check("rst_s_data_out", s_data_out, 8'h00);
      check("rst_s_out_branch", s_out_branch, 2'd0);
      check("rst_s_out_primed", s_out_primed, 1'b0);
      check("rst_s_sync_err", s_sync_err, 1'b0);
      check("rst_d_out_valid", d_out_valid, 1'b0);
      check("rst_d_data_out", d_data_out, 8'h00);
      reset = 1'b0;

      // continuous flow
      for (int k = 0; k < 18; k++) s_send(8'(k + 1), 1'b0);
      s_idle(4);
      check_table("cont");

      // backpressure at k=7
      do_reset();
      for (int k = 0; k < 8; k++) s_send(8'(k + 1), 1'b0);
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_data_in   = 8'h09;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_data", s_data_out, 8'h02);
         check("stall_branch", s_out_branch, 2'd1);
         check("stall_in_ready", s_in_ready, 1'b0);
         @(posedge clk); #1;
      end
      s_out_ready = 1'b1;
      for (int k = 8; k < 18; k++) s_send(8'(k + 1), 1'b0);
      s_idle(4);
      check_table("stall");

      // random idle gaps
      do_reset();
      for (int k = 0; k < 18; k++) begin
         if ($urandom_range(0, 1) == 1) s_idle($urandom_range(1, 3));
         s_send(8'(k + 1), 1'b0);
      end
      s_idle(4);
      check_table("gaps");

      // reset mid-stream
      do_reset();
      for (int k = 0; k < 9; k++) s_send(8'(k + 1), 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_out_valid", s_out_valid, 1'b0);
      check("midrst_data_out", s_data_out, 8'h00);
      check("midrst_out_primed", s_out_primed, 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 18; k++) s_send(8'(k + 1), 1'b0);
      s_idle(4);
      check_table("midrst");

      // sync realignment
      do_reset();
      for (int k = 0; k < 4; k++) s_send(8'(k + 1), 1'b0);
      s_send(8'h05, 1'b1);
`ifdef SYNC_ALIGN_EN
      check("sync_k4_branch", s_out_branch, 2'd0);
      check("sync_k4_data", s_data_out, 8'h05);
      check("sync_k4_primed", s_out_primed, 1'b1);
      check("sync_k4_err", s_sync_err, 1'b1);
`else
      check("sync_k4_branch", s_out_branch, 2'd1);
      check("sync_k4_data", s_data_out, 8'h00);
      check("sync_k4_primed", s_out_primed, 1'b0);
      check("sync_k4_err", s_sync_err, 1'b0);
`endif
      s_send(8'h06, 1'b0);
`ifdef SYNC_ALIGN_EN
      check("sync_k5_branch", s_out_branch, 2'd1);
`else
      check("sync_k5_branch", s_out_branch, 2'd2);
`endif
      check("sync_k5_err", s_sync_err, 1'b0);
      s_send(8'h07, 1'b0);
      s_send(8'h08, 1'b1);
`ifdef SYNC_ALIGN_EN
      check("sync_k7_branch", s_out_branch, 2'd0);
`else
      check("sync_k7_branch", s_out_branch, 2'd1);
`endif
      check("sync_k7_err", s_sync_err, 1'b0);
      s_idle(4);

      // long randomized stream on the default-size core
      do_reset();
      for (int n = 0; n < 2256; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            d_out_ready = 1'b1;
            @(posedge clk); #1;
         end
         d_send(8'($urandom_range(0, 255)));
      end
      d_out_ready = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("d_branch11_visits", (vis11 >= 188) ? 1 : 0, 1);
      check("drain_s", expq[0].size(), 0);
      check("drain_d", expq[1].size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
